// File: rtl/vga_lb_reader_pkg.sv
// Shared definitions for the VGA line-buffer reader and its camera-side writer.
// Holds the reader FSM encoding, the RGB565 field positions and the default
// line geometry. Keeping the geometry here lets both ends of the line buffer
// agree on it.
package vga_lb_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } lbRdState_t;

  // MSB position of each RGB565 field.
  localparam int unsigned R_MSB = 15;
  localparam int unsigned G_MSB = 10;
  localparam int unsigned B_MSB = 4;

  // Default line geometry.
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned ADDR_W_DEF   = 10;

endpackage

// File: rtl/vga_lb_reader_rgb565_expand.sv
// rgb565_expand: registered RGB565 -> 3 x 10-bit DAC expansion with 1-cycle latency.
// Ports:
//   CLK, RST_N : clock and asynchronous active-low reset
//   EN         : load PIX this cycle; the outputs hold when EN is low
//   PIX        : RGB565 input word
//   R, G, B    : expanded 10-bit channels
module rgb565_expand
  import vga_lb_reader_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        EN,
  input  logic [15:0] PIX,
  output logic [9:0]  R,
  output logic [9:0]  G,
  output logic [9:0]  B
);

  // Each channel replicates its own top bits into the low bits. Full scale
  // then maps to 10'h3FF and zero maps to 0. Green has a 6-bit field, so it
  // repeats only its top 4 bits to reach 10 bits.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      R <= '0;
      G <= '0;
      B <= '0;
    end else if (EN) begin
      R <= {PIX[R_MSB -: 5], PIX[R_MSB -: 5]};
      G <= {PIX[G_MSB -: 6], PIX[G_MSB -: 4]};
      B <= {PIX[B_MSB -: 5], PIX[B_MSB -: 5]};
    end
  end

endmodule

// File: rtl/vga_lb_reader.sv
// vga_lb_reader: read side of the ping-pong camera line buffer.
// It owns the bank select. The writer fills WR_BANK while this block streams
// the other bank. Each LINE_REQ streams H_ACTIVE RGB565 words, expands them
// to 10-bit channels, and marks each valid pixel with PIX_VALID.
// Ports:
//   CLK, RST_N            : clock and asynchronous active-low reset
//   LINE_REQ              : pulse that starts one line
//   BANK_SWAP             : pulse raised when the writer finishes a line
//   FRAME_RST             : pulse at the frame boundary
//   WR_BANK               : bank the writer targets
//   LB_RD_ADDR            : {rd_bank, word address}
//   LB_RD_N               : active-low read enable
//   LB_RD_DATA            : read data, RD_LAT cycles after the read
//   VGA_R/G/B, PIX_VALID  : expanded pixel and its strobe
//   BUSY                  : line in progress
//   REPEAT_CNT            : lines read since the last swap, saturates at 3
//   ERR_OVERLAP           : sticky, swap arrived during a line
//   ERR_REQ_DROP          : sticky, request arrived during a line
module vga_lb_reader
  import vga_lb_reader_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              LINE_REQ,
  input  logic              BANK_SWAP,
  input  logic              FRAME_RST,
  output logic              WR_BANK,
  output logic [ADDR_W:0]   LB_RD_ADDR,
  output logic              LB_RD_N,
  input  logic [15:0]       LB_RD_DATA,
  output logic [9:0]        VGA_R,
  output logic [9:0]        VGA_G,
  output logic [9:0]        VGA_B,
  output logic              PIX_VALID,
  output logic              BUSY,
  output logic [1:0]        REPEAT_CNT,
  output logic              ERR_OVERLAP,
  output logic              ERR_REQ_DROP
);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(H_ACTIVE - 1);
  localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT);

  lbRdState_t        state, stateNxt;
  logic [ADDR_W-1:0] addr, addrNxt;
  logic              rdBank, rdBankNxt;
  logic [1:0]        drainCnt, drainCntNxt;
  logic              lineDone;
  logic              reqDrop;
  logic [RD_LAT:0]   vldSr;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      addr     <= '0;
      rdBank   <= 1'b0;
      drainCnt <= '0;
    end else begin
      state    <= stateNxt;
      addr     <= addrNxt;
      rdBank   <= rdBankNxt;
      drainCnt <= drainCntNxt;
    end
  end

  always_comb begin
    stateNxt    = state;
    addrNxt     = addr;
    rdBankNxt   = rdBank;
    drainCntNxt = drainCnt;
    lineDone    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (LINE_REQ) begin
          stateNxt  = ST_STREAM;
          rdBankNxt = ~WR_BANK;
          addrNxt   = '0;
        end
      end
      ST_STREAM: begin
        if (addr == LAST_ADDR) begin
          stateNxt    = ST_DRAIN;
          addrNxt     = '0;
          drainCntNxt = '0;
        end else begin
          addrNxt = addr + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        // Hold for RD_LAT+1 cycles so the last read reaches PIX_VALID.
        if (drainCnt == DRAIN_LAST) begin
          stateNxt = ST_IDLE;
          lineDone = 1'b1;
        end else begin
          drainCntNxt = drainCnt + 2'd1;
        end
      end
      default: stateNxt = ST_IDLE;
    endcase
  end

  assign BUSY       = (state != ST_IDLE);
  assign LB_RD_N    = (state != ST_STREAM);
  assign LB_RD_ADDR = {rdBank, addr};
  assign reqDrop    = LINE_REQ && BUSY;

  // Bank, repeat and error bookkeeping. FRAME_RST overrides everything, and
  // a swap overrides the end-of-line repeat increment.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      WR_BANK      <= 1'b0;
      REPEAT_CNT   <= '0;
      ERR_OVERLAP  <= 1'b0;
      ERR_REQ_DROP <= 1'b0;
    end else if (FRAME_RST) begin
      WR_BANK      <= 1'b0;
      REPEAT_CNT   <= '0;
      ERR_OVERLAP  <= 1'b0;
      ERR_REQ_DROP <= 1'b0;
    end else begin
      if (BANK_SWAP) begin
        WR_BANK    <= ~WR_BANK;
        REPEAT_CNT <= '0;
        if (BUSY) ERR_OVERLAP <= 1'b1;
      end else if (lineDone && (REPEAT_CNT != 2'd3)) begin
        REPEAT_CNT <= REPEAT_CNT + 2'd1;
      end
      if (reqDrop) ERR_REQ_DROP <= 1'b1;
    end
  end

  // The read strobe is delayed along with the data. Tap RD_LAT-1 marks the
  // cycle the read data arrives. Tap RD_LAT lines up with the expander output.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) vldSr <= '0;
    else        vldSr <= {vldSr[RD_LAT-1:0], ~LB_RD_N};
  end

  assign PIX_VALID = vldSr[RD_LAT];

  rgb565_expand uExpand (
    .CLK   (CLK),
    .RST_N (RST_N),
    .EN    (vldSr[RD_LAT-1]),
    .PIX   (LB_RD_DATA),
    .R     (VGA_R),
    .G     (VGA_G),
    .B     (VGA_B)
  );

endmodule

// File: tb/tb_vga_lb_reader.sv
module tb_vga_lb_reader;

  localparam int H  = 640;
  localparam int RL = 1;

  logic        CLK, RST_N, LINE_REQ, BANK_SWAP, FRAME_RST;
  logic        WR_BANK, LB_RD_N, PIX_VALID, BUSY, ERR_OVERLAP, ERR_REQ_DROP;
  logic [10:0] LB_RD_ADDR;
  logic [15:0] LB_RD_DATA;
  logic [9:0]  VGA_R, VGA_G, VGA_B;
  logic [1:0]  REPEAT_CNT;

  vga_lb_reader #(.H_ACTIVE(H), .ADDR_W(10), .RD_LAT(RL)) dut (
    .CLK(CLK), .RST_N(RST_N), .LINE_REQ(LINE_REQ), .BANK_SWAP(BANK_SWAP),
    .FRAME_RST(FRAME_RST), .WR_BANK(WR_BANK), .LB_RD_ADDR(LB_RD_ADDR),
    .LB_RD_N(LB_RD_N), .LB_RD_DATA(LB_RD_DATA), .VGA_R(VGA_R), .VGA_G(VGA_G),
    .VGA_B(VGA_B), .PIX_VALID(PIX_VALID), .BUSY(BUSY), .REPEAT_CNT(REPEAT_CNT),
    .ERR_OVERLAP(ERR_OVERLAP), .ERR_REQ_DROP(ERR_REQ_DROP)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int nTests = 0;
  int nFail  = 0;
  int nPrint = 0;
  int cyc    = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Line buffer with a one-cycle registered read port.
  logic [15:0] mem [0:2047];
  logic [15:0] rdData = '0;
  always @(posedge CLK) if (!LB_RD_N) rdData <= mem[LB_RD_ADDR];
  assign LB_RD_DATA = rdData;

  // Pixel expansion computed directly from the channel values.
  function automatic logic [29:0] expRgb(input logic [15:0] d);
    int unsigned r5, g6, b5;
    r5 = (d >> 11) & 31;
    g6 = (d >> 5) & 63;
    b5 = d & 31;
    return {10'((r5 << 5) | r5), 10'((g6 << 4) | (g6 >> 2)), 10'((b5 << 5) | b5)};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    nTests++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Reference model. A line accepted at edge T occupies cycles [T, T+H+RL]:
  // it reads during [T, T+H-1] and shows pixels during [T+1+RL, T+H+RL].
  bit mActive = 0;
  int mT = 0;
  bit mRdBank = 0, mWrBank = 0, mOvl = 0, mDrop = 0;
  int mRep = 0;

  always @(posedge CLK or negedge RST_N) begin
    bit busyPrev, lineEnd;
    if (!RST_N) begin
      mActive <= 0; mT <= 0; mRdBank <= 0; mWrBank <= 0;
      mRep <= 0; mOvl <= 0; mDrop <= 0;
    end else begin
      busyPrev = mActive && cyc >= mT && cyc <= mT + H + RL;
      lineEnd  = mActive && cyc == mT + H + RL;
      if (LINE_REQ && !busyPrev) begin
        mActive <= 1; mT <= cyc + 1; mRdBank <= ~mWrBank;
      end
      if (FRAME_RST) begin
        mWrBank <= 0; mRep <= 0; mOvl <= 0; mDrop <= 0;
      end else begin
        if (BANK_SWAP) begin
          mWrBank <= ~mWrBank; mRep <= 0;
          if (busyPrev) mOvl <= 1;
        end else if (lineEnd && mRep < 3) begin
          mRep <= mRep + 1;
        end
        if (LINE_REQ && busyPrev) mDrop <= 1;
      end
    end
  end

  // Every cycle, compare all outputs with the model.
  always @(negedge CLK) begin
    int c, idx;
    bit eBusy, eStream, eValid, ok;
    logic [10:0] eAddr;
    logic [29:0] ePix;
    c       = cyc;
    eBusy   = mActive && c >= mT && c <= mT + H + RL;
    eStream = mActive && c >= mT && c <= mT + H - 1;
    eValid  = mActive && c >= mT + 1 + RL && c <= mT + H + RL;
    eAddr   = {mRdBank, eStream ? 10'(c - mT) : 10'd0};
    idx     = c - mT - 1 - RL;
    ePix    = eValid ? expRgb(mem[{mRdBank, 10'(idx)}]) : '0;
    ok = (BUSY == eBusy) && (LB_RD_N == !eStream) && (LB_RD_ADDR == eAddr) &&
         (PIX_VALID == eValid) && (WR_BANK == mWrBank) && (int'(REPEAT_CNT) == mRep) &&
         (ERR_OVERLAP == mOvl) && (ERR_REQ_DROP == mDrop);
    if (eValid && {VGA_R, VGA_G, VGA_B} != ePix) ok = 0;
    nTests++;
    if (!ok) begin
      nFail++;
      if (nPrint < 10) begin
        nPrint++;
        $display("FAIL cycle %0d: got busy=%b rdn=%b addr=%h pv=%b rgb=%h wb=%b rep=%0d ovl=%b drop=%b; expected busy=%b rdn=%b addr=%h pv=%b rgb=%h wb=%b rep=%0d ovl=%b drop=%b",
                 c, BUSY, LB_RD_N, LB_RD_ADDR, PIX_VALID, {VGA_R, VGA_G, VGA_B}, WR_BANK,
                 REPEAT_CNT, ERR_OVERLAP, ERR_REQ_DROP, eBusy, !eStream, eAddr, eValid,
                 ePix, mWrBank, mRep, mOvl, mDrop);
      end
    end
  end

  // Per-line monitor.
  int vCount = 0, firstValidCyc = -1, lastAddr = -1, firstAddr = -1, bankSeen = -1;
  bit bankMix = 0;
  logic [29:0] pixQ[$];
  always @(negedge CLK) begin
    if (PIX_VALID) begin
      if (vCount == 0) firstValidCyc = cyc;
      vCount++;
      pixQ.push_back({VGA_R, VGA_G, VGA_B});
    end
    if (!LB_RD_N) begin
      if (firstAddr < 0) firstAddr = int'(LB_RD_ADDR[9:0]);
      if (bankSeen >= 0 && bankSeen != int'(LB_RD_ADDR[10])) bankMix = 1;
      bankSeen = int'(LB_RD_ADDR[10]);
      lastAddr = int'(LB_RD_ADDR[9:0]);
    end
  end

  int tReq;

  task automatic startLine();
    @(negedge CLK); LINE_REQ = 1'b1;
    @(posedge CLK); #1;
    tReq = cyc; vCount = 0; firstValidCyc = -1; lastAddr = -1; firstAddr = -1;
    bankSeen = -1; bankMix = 0; pixQ.delete();
    @(negedge CLK); LINE_REQ = 1'b0;
  endtask

  task automatic waitIdle(input string nm);
    int n;
    n = 0;
    do begin @(negedge CLK); n++; end while (BUSY && n < 3000);
    chk({nm, "_idle"}, int'(BUSY), 0);
  endtask

  task automatic waitAddr(input int a, input string nm);
    int n;
    bit found;
    n = 0; found = 0;
    while (!found && n < 2000) begin
      if (!LB_RD_N && int'(LB_RD_ADDR[9:0]) == a) found = 1;
      else begin @(negedge CLK); n++; end
    end
    chk({nm, "_addr_reached"}, int'(found), 1);
  endtask

  task automatic pulseSwap();
    @(negedge CLK); BANK_SWAP = 1'b1;
    @(negedge CLK); BANK_SWAP = 1'b0;
  endtask

  typedef struct { logic [15:0] d; logic [29:0] e; } vec_t;
  vec_t tbl [7];

  initial begin
    RST_N = 1'b0; LINE_REQ = 1'b0; BANK_SWAP = 1'b0; FRAME_RST = 1'b0;
    tbl[0] = '{16'hF800, {10'h3FF, 10'h000, 10'h000}};
    tbl[1] = '{16'h07E0, {10'h000, 10'h3FF, 10'h000}};
    tbl[2] = '{16'h001F, {10'h000, 10'h000, 10'h3FF}};
    tbl[3] = '{16'hFFFF, {10'h3FF, 10'h3FF, 10'h3FF}};
    tbl[4] = '{16'h0000, {10'h000, 10'h000, 10'h000}};
    tbl[5] = '{16'h0001, {10'h000, 10'h000, 10'h021}};
    tbl[6] = '{16'h8410, {10'h210, 10'h208, 10'h210}};
    for (int i = 0; i < 2048; i++)
      mem[i] = (i < 1024) ? (16'(i) ^ 16'h5A00) : 16'(i - 1024);

    repeat (3) @(negedge CLK);
    chk("rst_lb_rd_n", int'(LB_RD_N), 1);
    chk("rst_addr", int'(LB_RD_ADDR), 0);
    chk("rst_pix_valid", int'(PIX_VALID), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_rgb", int'({VGA_R, VGA_G, VGA_B}), 0);
    chk("rst_wr_bank", int'(WR_BANK), 0);
    chk("rst_repeat", int'(REPEAT_CNT), 0);
    chk("rst_errs", int'({ERR_OVERLAP, ERR_REQ_DROP}), 0);
    RST_N = 1'b1;

    // First line: bank 1, word n = n.
    startLine();
    waitIdle("l1");
    chk("l1_first_valid_latency", firstValidCyc - tReq, 1 + RL);
    chk("l1_valid_cnt", vCount, H);
    chk("l1_first_addr", firstAddr, 0);
    chk("l1_last_addr", lastAddr, H - 1);
    chk("l1_bank", bankSeen, 1);
    chk("l1_word1_rgb", int'(pixQ[1]), 'h021);
    chk("l1_repeat", int'(REPEAT_CNT), 1);

    // Table of colour vectors, loaded into the bank that is read next.
    for (int i = 0; i < 7; i++) mem[1024 + i] = tbl[i].d;
    startLine();
    waitIdle("tbl");
    for (int i = 0; i < 7; i++) chk($sformatf("tbl_rgb_%04h", tbl[i].d), int'(pixQ[i]), int'(tbl[i].e));
    chk("tbl_repeat", int'(REPEAT_CNT), 2);

    // Swap in IDLE, then four lines without a swap.
    pulseSwap();
    chk("swap_idle_wr_bank", int'(WR_BANK), 1);
    chk("swap_idle_repeat", int'(REPEAT_CNT), 0);
    for (int k = 0; k < 4; k++) begin
      startLine();
      waitIdle("rep");
      chk($sformatf("rep_bank_%0d", k), bankSeen, 0);
      chk($sformatf("rep_cnt_%0d", k), int'(REPEAT_CNT), (k < 3) ? k + 1 : 3);
    end

    // Swap in mid-line at address 300.
    startLine();
    waitAddr(300, "ovl");
    BANK_SWAP = 1'b1;
    @(negedge CLK); BANK_SWAP = 1'b0;
    chk("ovl_flag", int'(ERR_OVERLAP), 1);
    chk("ovl_wr_bank", int'(WR_BANK), 0);
    waitIdle("ovl");
    chk("ovl_valid_cnt", vCount, H);
    chk("ovl_bank", bankSeen, 0);
    chk("ovl_bank_stable", int'(bankMix), 0);
    chk("ovl_repeat", int'(REPEAT_CNT), 1);

    // Request in mid-line at address 100.
    startLine();
    waitAddr(100, "drop");
    LINE_REQ = 1'b1;
    @(negedge CLK); LINE_REQ = 1'b0;
    chk("drop_flag", int'(ERR_REQ_DROP), 1);
    waitIdle("drop");
    chk("drop_valid_cnt", vCount, H);
    chk("drop_bank", bankSeen, 1);
    pulseSwap();
    chk("pre_frst_wr_bank", int'(WR_BANK), 1);
    @(negedge CLK); FRAME_RST = 1'b1;
    @(negedge CLK); FRAME_RST = 1'b0;
    chk("frst_errs", int'({ERR_OVERLAP, ERR_REQ_DROP}), 0);
    chk("frst_wr_bank", int'(WR_BANK), 0);
    chk("frst_repeat", int'(REPEAT_CNT), 0);

    // Asynchronous reset at address 200.
    startLine();
    waitAddr(200, "arst");
    chk("arst_pre_valid", int'(PIX_VALID), 1);
    #2 RST_N = 1'b0;
    #1;
    chk("arst_pix_valid", int'(PIX_VALID), 0);
    chk("arst_lb_rd_n", int'(LB_RD_N), 1);
    chk("arst_busy", int'(BUSY), 0);
    @(negedge CLK); RST_N = 1'b1;
    startLine();
    waitIdle("arst");
    chk("arst_restart_addr", firstAddr, 0);
    chk("arst_restart_bank", bankSeen, 1);
    chk("arst_restart_valid_cnt", vCount, H);

    // Random pulses against the model.
    for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 9000; i++) begin
      @(negedge CLK);
      LINE_REQ  = ($urandom_range(0, 199) == 0);
      BANK_SWAP = ($urandom_range(0, 299) == 0);
      FRAME_RST = ($urandom_range(0, 999) == 0);
    end
    @(negedge CLK);
    LINE_REQ = 1'b0; BANK_SWAP = 1'b0; FRAME_RST = 1'b0;
    waitIdle("rand");

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
